// File: rtl/fpt_pkg.sv
// Shared types and helpers for the multichannel FPT correction core:
// attention level encodings, DW-bit saturation and packed-bus slice indexing.
package fpt_pkg;

   typedef enum logic [1:0] {
      ATTN_LOW  = 2'd0,
      ATTN_MID  = 2'd1,
      ATTN_HIGH = 2'd2,
      ATTN_VETO = 2'd3
   } attn_e;

   // Clamp a signed value to the range of a dw-bit two's complement number.
   function automatic logic [31:0] sat_dw(input logic signed [32:0] v, input int dw);
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      hi = (33'sd1 <<< (dw - 1)) - 33'sd1;
      lo = -(33'sd1 <<< (dw - 1));
      if (v > hi) begin
         return hi[31:0];
      end else if (v < lo) begin
         return lo[31:0];
      end
      return v[31:0];
   endfunction

   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction

   function automatic attn_e attn_of(input logic [31:0] mag, input logic [31:0] t1,
                                     input logic [31:0] t2, input logic [31:0] t3);
      if (mag < t1) begin
         return ATTN_LOW;
      end else if (mag < t2) begin
         return ATTN_MID;
      end else if (mag < t3) begin
         return ATTN_HIGH;
      end
      return ATTN_VETO;
   endfunction

endpackage

// File: rtl/fpt_rr_arbiter.sv
// Round-robin request arbiter: grants the first requester at or after the
// pointer (wrapping) and moves the pointer past the winner on accept.
module fpt_rr_arbiter
   import fpt_pkg::*;
#(
   parameter int NCH = 4
)(
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NCH-1:0]            i_req,
   input  logic                      i_accept,
   output logic [NCH-1:0]            o_grant,
   output logic [$clog2(NCH)-1:0]    o_gidx,
   output logic                      o_gvalid,
   output logic [$clog2(NCH)-1:0]    o_ptr
);

   localparam int CW = $clog2(NCH);

   logic [CW-1:0] r_ptr;
   logic [CW:0]   w_sum;
   logic [CW-1:0] w_idx;

   always_comb begin
      o_grant  = '0;
      o_gidx   = '0;
      o_gvalid = 1'b0;
      w_sum    = '0;
      w_idx    = '0;
      for (int k = 0; k < NCH; k++) begin
         w_sum = {1'b0, r_ptr} + (CW+1)'(k);
         if (w_sum >= (CW+1)'(NCH)) begin
            w_sum = w_sum - (CW+1)'(NCH);
         end
         w_idx = w_sum[CW-1:0];
         if (!o_gvalid && i_req[w_idx]) begin
            o_gvalid       = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_gidx         = w_idx;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (i_accept) begin
         r_ptr <= (o_gidx == CW'(NCH - 1)) ? '0 : o_gidx + CW'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/fpt_multichannel_core.sv
// Multichannel FPT core: round-robin intake, shared 2-stage correction pipe,
// per-channel veto hysteresis and attention. Option macro: FPT_VETO_STICKY_EN.
module fpt_multichannel_core
   import fpt_pkg::*;
#(
   parameter int NCH         = 4,
   parameter int DW          = 16,
   parameter int VETO_THRESH = 4096,
   parameter int VETO_HOLD   = 4,
   parameter int RELEASE_CNT = 8,
   parameter int ATTN_T1     = 512,
   parameter int ATTN_T2     = 2048,
   parameter int LED_STRETCH = 16
)(
   input  logic                     clk_250mhz,
   input  logic                     rst,
   input  logic [NCH-1:0]           in_valid,
   output logic [NCH-1:0]           in_ready,
   input  logic [NCH*DW-1:0]        sensor_scrape,
   input  logic [NCH*DW-1:0]        motor_command,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(NCH)-1:0]   out_chan,
   output logic [DW-1:0]            motor_correction,
   output logic [NCH-1:0]           veto_out,
   output logic [2*NCH-1:0]         attention_level,
   input  logic                     veto_clear,
   output logic                     led_red,
   output logic                     led_green
);

   localparam int CW = $clog2(NCH);
   localparam int OW = $clog2(VETO_HOLD + 1);
   localparam int UW = $clog2(RELEASE_CNT + 1);
   localparam logic [DW:0]   L_THRESH = (DW+1)'(VETO_THRESH);
   localparam logic [OW-1:0] L_HOLD   = OW'(VETO_HOLD);
   localparam logic [UW-1:0] L_REL    = UW'(RELEASE_CNT);

   // Handshake: a beat moves when valid and ready are both high at a rising edge;
   // a presented result stays frozen until out_ready, and nothing is accepted meanwhile.

   logic [NCH-1:0] w_grant;
   logic [CW-1:0]  w_gidx;
   logic           w_gvalid;
   logic [CW-1:0]  w_ptr_unused;
   logic           w_stall;
   logic           w_accept;
   logic           w_s2_fire;
   logic           w_out_hs;
   logic [DW-1:0]  w_sen;
   logic [DW-1:0]  w_mot;
   logic [DW:0]    w_err_in;

   logic           r_s1_valid;
   logic [CW-1:0]  r_s1_chan;
   logic [DW:0]    r_s1_err;

   logic [DW:0]    w_mag;
   logic           w_over;
   attn_e          w_attn;
   logic [OW-1:0]  w_over_nxt;
   logic [UW-1:0]  w_under_nxt;
   logic           w_veto_cur;
   logic           w_veto_nxt;
   logic [DW-1:0]  w_sat;

   logic                   r_out_valid;
   logic [CW-1:0]          r_out_chan;
   logic [DW-1:0]          r_corr;
   logic [NCH-1:0]         r_veto;
   attn_e                  r_attn      [NCH];
   logic [OW-1:0]          r_over_cnt  [NCH];
   logic [UW-1:0]          r_under_cnt [NCH];
   logic [LED_STRETCH-1:0] r_stretch;

   assign w_stall   = r_out_valid & ~out_ready;
   assign w_accept  = w_gvalid & ~w_stall;
   assign w_s2_fire = r_s1_valid & ~w_stall;
   assign w_out_hs  = r_out_valid & out_ready;
   assign in_ready  = w_stall ? '0 : w_grant;

   fpt_rr_arbiter #(
      .NCH (NCH)
   ) u_arb (
      .i_clk    (clk_250mhz),
      .i_rst    (rst),
      .i_req    (in_valid),
      .i_accept (w_accept),
      .o_grant  (w_grant),
      .o_gidx   (w_gidx),
      .o_gvalid (w_gvalid),
      .o_ptr    (w_ptr_unused)
   );

   always_comb begin
      w_sen = '0;
      w_mot = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_grant[i]) begin
            w_sen = sensor_scrape[slice_lo(i, DW) +: DW];
            w_mot = motor_command[slice_lo(i, DW) +: DW];
         end
      end
   end

   // One extra bit keeps the difference of two DW-bit signed values exact.
   assign w_err_in = {w_mot[DW-1], w_mot} - {w_sen[DW-1], w_sen};

   always_comb begin
      w_mag      = r_s1_err[DW] ? -r_s1_err : r_s1_err;
      w_over     = (w_mag >= L_THRESH);
      w_attn     = attn_of(32'(w_mag), 32'(ATTN_T1), 32'(ATTN_T2), 32'(VETO_THRESH));
      w_veto_cur = r_veto[r_s1_chan];
      w_over_nxt = '0;
      w_under_nxt = '0;
      if (w_over) begin
         w_over_nxt = (r_over_cnt[r_s1_chan] == L_HOLD) ? L_HOLD : r_over_cnt[r_s1_chan] + OW'(1);
      end else begin
         w_under_nxt = (r_under_cnt[r_s1_chan] == L_REL) ? L_REL : r_under_cnt[r_s1_chan] + UW'(1);
      end
`ifdef FPT_VETO_STICKY_EN
      w_veto_nxt = (w_over_nxt == L_HOLD) ? 1'b1 : (veto_clear ? 1'b0 : w_veto_cur);
`else
      w_veto_nxt = (w_over_nxt == L_HOLD) ? 1'b1 : ((w_under_nxt == L_REL) ? 1'b0 : w_veto_cur);
`endif
      w_sat = DW'(sat_dw(33'($signed(r_s1_err)), DW));
   end

`ifndef FPT_VETO_STICKY_EN
   logic w_clear_unused;
   assign w_clear_unused = veto_clear;
`endif

   always_ff @(posedge clk_250mhz) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_chan   <= '0;
         r_s1_err    <= '0;
         r_out_valid <= 1'b0;
         r_out_chan  <= '0;
         r_corr      <= '0;
      end else if (!w_stall) begin
         r_s1_valid  <= w_accept;
         if (w_accept) begin
            r_s1_chan <= w_gidx;
            r_s1_err  <= w_err_in;
         end
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_chan <= r_s1_chan;
            r_corr     <= w_veto_nxt ? '0 : w_sat;
         end
      end
   end

   // Clear is applied first so a veto asserting in the same cycle overrides it.
   always_ff @(posedge clk_250mhz) begin
      if (rst) begin
         r_veto <= '0;
         for (int i = 0; i < NCH; i++) begin
            r_attn[i]      <= ATTN_LOW;
            r_over_cnt[i]  <= '0;
            r_under_cnt[i] <= '0;
         end
      end else begin
`ifdef FPT_VETO_STICKY_EN
         if (veto_clear) begin
            r_veto <= '0;
            for (int i = 0; i < NCH; i++) begin
               r_over_cnt[i]  <= '0;
               r_under_cnt[i] <= '0;
            end
         end
`endif
         if (w_s2_fire) begin
            r_veto[r_s1_chan]      <= w_veto_nxt;
            r_attn[r_s1_chan]      <= w_attn;
            r_over_cnt[r_s1_chan]  <= w_over_nxt;
            r_under_cnt[r_s1_chan] <= w_under_nxt;
         end
      end
   end

   always_ff @(posedge clk_250mhz) begin
      if (rst) begin
         r_stretch <= '0;
      end else if (w_out_hs) begin
         r_stretch <= '1;
      end else if (r_stretch != '0) begin
         r_stretch <= r_stretch - LED_STRETCH'(1);
      end
   end

   always_comb begin
      attention_level = '0;
      for (int i = 0; i < NCH; i++) begin
         attention_level[slice_lo(i, 2) +: 2] = r_attn[i];
      end
   end

   assign out_valid        = r_out_valid;
   assign out_chan         = r_out_chan;
   assign motor_correction = r_corr;
   assign veto_out         = r_veto;
   assign led_red          = |r_veto;
   assign led_green        = ~led_red & (|r_stretch);

endmodule

// File: tb/tb_fpt_multichannel_core.sv
// Scoreboard bench for fpt_multichannel_core; honours FPT_VETO_STICKY_EN when defined.
module tb_fpt_multichannel_core;

   localparam int NCH  = 4;
   localparam int DW   = 16;
   localparam int CW   = 2;
   localparam int W    = CW + DW + 1 + 2;
   localparam int MAXS = 40;

   logic                clk;
   logic                rst;
   logic [NCH-1:0]      in_valid;
   logic [NCH-1:0]      in_ready;
   logic [NCH*DW-1:0]   sensor_scrape;
   logic [NCH*DW-1:0]   motor_command;
   logic                out_valid;
   logic                out_ready;
   logic [CW-1:0]       out_chan;
   logic [DW-1:0]       motor_correction;
   logic [NCH-1:0]      veto_out;
   logic [2*NCH-1:0]    attention_level;
   logic                veto_clear;
   logic                led_red;
   logic                led_green;

   fpt_multichannel_core #(
      .NCH(NCH), .DW(DW), .VETO_THRESH(4096), .VETO_HOLD(4), .RELEASE_CNT(8),
      .ATTN_T1(512), .ATTN_T2(2048), .LED_STRETCH(16)
   ) dut (
      .clk_250mhz       (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .sensor_scrape    (sensor_scrape),
      .motor_command    (motor_command),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_chan         (out_chan),
      .motor_correction (motor_correction),
      .veto_out         (veto_out),
      .attention_level  (attention_level),
      .veto_clear       (veto_clear),
      .led_red          (led_red),
      .led_green        (led_green)
   );

   // clock / reset
   initial clk = 1'b0;
   always #2 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard and reference model state
   logic [W-1:0] exp_q[$];
   int           lat_q[$];
   int           m_over  [NCH];
   int           m_under [NCH];
   bit           m_veto  [NCH];
   int           m_ptr;
   int           cyc;
   bit           lat_chk;
   bit           rdy_rand;
   int           rdy_low;
   bit           stalled_prev;
   logic [30:0]  snap;

   logic signed [DW-1:0] st_sen [NCH][MAXS];
   logic signed [DW-1:0] st_mot [NCH][MAXS];
   int                   st_cnt [NCH];
   int                   st_idx [NCH];

   function automatic logic [30:0] pack_out();
      return {out_valid, out_chan, motor_correction, veto_out, attention_level};
   endfunction

   function automatic bit pending();
      for (int i = 0; i < NCH; i++) begin
         if (st_idx[i] < st_cnt[i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic add(input int ch, input int sen, input int mot);
      st_sen[ch][st_cnt[ch]] = DW'(sen);
      st_mot[ch][st_cnt[ch]] = DW'(mot);
      st_cnt[ch]++;
   endtask

   task automatic clear_stim();
      for (int i = 0; i < NCH; i++) begin
         st_cnt[i] = 0;
         st_idx[i] = 0;
      end
   endtask

   task automatic model_accept(input int ch, input logic signed [DW-1:0] sen,
                               input logic signed [DW-1:0] mot);
      int         e;
      int         mag;
      int         corr;
      logic [1:0] at;
      e   = int'(mot) - int'(sen);
      mag = (e < 0) ? -e : e;
      at  = (mag < 512) ? 2'd0 : (mag < 2048) ? 2'd1 : (mag < 4096) ? 2'd2 : 2'd3;
      if (mag >= 4096) begin
         m_under[ch] = 0;
         if (m_over[ch] < 4) m_over[ch]++;
         if (m_over[ch] == 4) m_veto[ch] = 1'b1;
      end else begin
         m_over[ch] = 0;
         if (m_under[ch] < 8) m_under[ch]++;
`ifndef FPT_VETO_STICKY_EN
         if (m_under[ch] == 8) m_veto[ch] = 1'b0;
`endif
      end
      corr = (e > 32767) ? 32767 : (e < -32768) ? -32768 : e;
      if (m_veto[ch]) corr = 0;
      exp_q.push_back({CW'(ch), DW'(corr), m_veto[ch], at});
      lat_q.push_back(cyc);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_over[i]  = 0;
         m_under[i] = 0;
         m_veto[i]  = 1'b0;
      end
      m_ptr = 0;
      exp_q.delete();
      lat_q.delete();
      stalled_prev = 1'b0;
   endtask

   // driver: called just after a rising edge
   task automatic drive_inputs();
      for (int i = 0; i < NCH; i++) begin
         if (st_idx[i] < st_cnt[i]) begin
            in_valid[i] = 1'b1;
            sensor_scrape[i*DW +: DW] = st_sen[i][st_idx[i]];
            motor_command[i*DW +: DW] = st_mot[i][st_idx[i]];
         end else begin
            in_valid[i] = 1'b0;
         end
      end
      if (rdy_low > 0) begin
         out_ready = 1'b0;
         rdy_low--;
      end else begin
         out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   // monitor: called at the falling edge, when handshakes are settled
   task automatic monitor_cycle();
      logic [NCH-1:0] exp_grant;
      logic [W-1:0]   e;
      int             ch;
      int             l;
      exp_grant = '0;
      for (int k = 0; k < NCH; k++) begin
         int j;
         j = (m_ptr + k) % NCH;
         if (exp_grant == '0 && in_valid[j]) exp_grant[j] = 1'b1;
      end
      if (out_valid && !out_ready) begin
         check("stall_in_ready", 32'(in_ready), 32'(0));
      end else begin
         check("rr_grant", 32'(in_ready), 32'(exp_grant));
      end
      if (stalled_prev) check("stall_hold", 32'(pack_out()), 32'(snap));
      for (int i = 0; i < NCH; i++) begin
         if (in_valid[i] && in_ready[i]) begin
            model_accept(i, st_sen[i][st_idx[i]], st_mot[i][st_idx[i]]);
            st_idx[i]++;
            m_ptr = (i + 1) % NCH;
         end
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(1), 32'(0));
         end else begin
            e  = exp_q.pop_front();
            l  = lat_q.pop_front();
            ch = int'(e[W-1 -: CW]);
            check("out_chan", 32'(out_chan), 32'(e[W-1 -: CW]));
            check("correction", 32'(motor_correction), 32'(e[DW+2:3]));
            check("veto_bit", 32'(veto_out[ch]), 32'(e[2]));
            check("attention", 32'(attention_level[2*ch +: 2]), 32'(e[1:0]));
            if (lat_chk) check("latency", 32'(cyc - l), 32'(2));
         end
      end
      stalled_prev = out_valid & ~out_ready;
      snap         = pack_out();
      cyc++;
   endtask

   task automatic run_stream(input int max_cyc);
      int n;
      n = 0;
      while ((pending() || exp_q.size() != 0) && n < max_cyc) begin
         drive_inputs();
         @(negedge clk);
         monitor_cycle();
         @(posedge clk);
         #1;
         n++;
      end
      check("stream_done", 32'(n < max_cyc), 32'(1));
      in_valid  = '0;
      out_ready = 1'b1;
      clear_stim();
   endtask

   task automatic run_idle(input int n);
      for (int k = 0; k < n; k++) begin
         drive_inputs();
         @(negedge clk);
         monitor_cycle();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = '0;
      out_ready = 1'b1;
      veto_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic pulse_clear();
      veto_clear = 1'b1;
      @(posedge clk);
      #1;
      veto_clear = 1'b0;
`ifdef FPT_VETO_STICKY_EN
      for (int i = 0; i < NCH; i++) begin
         m_veto[i]  = 1'b0;
         m_over[i]  = 0;
         m_under[i] = 0;
      end
`endif
      @(negedge clk);
   endtask

   initial begin
      in_valid = '0;
      sensor_scrape = '0;
      motor_command = '0;
      out_ready = 1'b1;
      veto_clear = 1'b0;
      rst = 1'b0;
      cyc = 0;
      lat_chk = 1'b1;
      rdy_rand = 1'b0;
      rdy_low = 0;
      clear_stim();

      // reset state
      do_reset();
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(0));
      check("rst_veto", 32'(veto_out), 32'(0));
      check("rst_attn", 32'(attention_level), 32'(0));
      check("rst_corr", 32'(motor_correction), 32'(0));
      check("rst_chan", 32'(out_chan), 32'(0));
      check("rst_leds", 32'({led_red, led_green}), 32'(0));
      @(posedge clk);
      #1;

      // all channels valid, full throughput, small errors
      for (int i = 0; i < NCH; i++) begin
         for (int s = 0; s < 4; s++) add(i, $urandom_range(0, 1500), $urandom_range(0, 1500));
      end
      run_stream(200);
      check("led_green_active", 32'(led_green), 32'(1));

      // saturation extremes
      add(2, -32768, 32767);
      add(3, 32767, -32768);
      add(0, 1000, -2000);
      run_stream(100);

      // veto on channel 1
      for (int s = 0; s < 4; s++) add(1, 0, 5000);
      run_stream(100);
      check("veto_set", 32'(veto_out[1]), 32'(1));
      check("led_red_on", 32'({led_red, led_green}), 32'(2'b10));
`ifdef FPT_VETO_STICKY_EN
      for (int s = 0; s < 20; s++) add(1, 0, 100);
      run_stream(200);
      check("sticky_hold", 32'(veto_out[1]), 32'(1));
      pulse_clear();
      check("sticky_clear", 32'(veto_out), 32'(0));
      @(posedge clk);
      #1;
`else
      pulse_clear();
      check("clear_ignored", 32'(veto_out[1]), 32'(1));
      @(posedge clk);
      #1;
      for (int s = 0; s < 7; s++) add(1, 0, 100);
      run_stream(100);
      check("veto_hold7", 32'(veto_out[1]), 32'(1));
      add(1, 0, 100);
      run_stream(100);
      check("veto_release", 32'(veto_out[1]), 32'(0));
`endif

      // backpressure: out_ready low with two results in flight
      lat_chk = 1'b0;
      rdy_low = 7;
      add(0, 10, 900);
      add(3, -300, 300);
      add(0, 50, -50);
      run_stream(100);
      rdy_rand = 1'b1;
      for (int s = 0; s < 20; s++) begin
         add($urandom_range(0, NCH-1), $urandom_range(0, 6000) - 3000, $urandom_range(0, 6000) - 3000);
      end
      run_stream(400);
      rdy_rand = 1'b0;
      run_idle(4);

      // reset with a full pipe and a live veto
      for (int s = 0; s < 4; s++) add(0, 5000, 0);
      run_stream(100);
      check("pre_rst_veto", 32'(veto_out[0]), 32'(1));
      for (int i = 0; i < NCH; i++) add(i, 1, 2);
      for (int k = 0; k < 3; k++) begin
         drive_inputs();
         @(negedge clk);
         monitor_cycle();
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = '0;
      model_reset();
      clear_stim();
      @(negedge clk);
      check("mid_rst_out_valid", 32'(out_valid), 32'(0));
      check("mid_rst_veto", 32'(veto_out), 32'(0));
      @(posedge clk);
      #1;
      lat_chk = 1'b1;
      for (int i = 0; i < NCH; i++) add(i, 200, -100);
      run_stream(100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
